// File: rtl/multilane_ddr_serialiser.sv
// N-lane word serialiser: W_OUT bits per lane per clock, LSB first, from a shallow shared word FIFO.
// Idle-word substitution on underrun, per-lane polarity swap, registered true/complement outputs.
module multilane_ddr_serialiser #(
    parameter int unsigned N_LANES = 3,
    parameter int unsigned W_WORD  = 10,
    parameter int unsigned W_OUT   = 2,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [N_LANES*W_WORD-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_LANES*W_WORD-1:0] idle_word,
    input  logic [N_LANES-1:0]        invert,
    output logic [N_LANES*W_OUT-1:0]  out_p,
    output logic [N_LANES*W_OUT-1:0]  out_n,
    output logic                      underflow
);
    localparam int unsigned BEATS = W_WORD / W_OUT;
    localparam int unsigned W_BUS = N_LANES * W_WORD;
    localparam int unsigned W_OB  = N_LANES * W_OUT;
    localparam int unsigned PW    = $clog2(BEATS);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PH = PW'(BEATS - 1);
    localparam logic [AW-1:0] LAST_AD = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [W_BUS-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [W_BUS-1:0] shift_q, shift_d;
    logic [W_OB-1:0]  out_p_q, out_p_d, out_n_q, out_n_d;
    logic             udf_pend_q, udf_pend_d;
    logic             underflow_q, underflow_d;
    logic             push, pop, load, empty;

    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign load     = en && (phase_q == '0);
    assign empty    = (count_q == '0);
    assign pop      = load && !empty;

    assign out_p     = out_p_q;
    assign out_n     = out_n_q;
    assign underflow = underflow_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_AD) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_AD) ? '0 : rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Underrun flag is delayed one extra cycle so it lines up with beat 0 of the idle word.
    always_comb begin
        phase_d     = '0;
        shift_d     = '0;
        out_p_d     = '0;
        out_n_d     = '0;
        udf_pend_d  = 1'b0;
        underflow_d = 1'b0;
        if (en) begin
            phase_d     = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
            udf_pend_d  = load && empty;
            underflow_d = udf_pend_q;
            if (load) begin
                shift_d = empty ? idle_word : mem_q[rd_ptr_q];
            end else begin
                for (int unsigned l = 0; l < N_LANES; l++) begin
                    shift_d[l*W_WORD +: W_WORD] = shift_q[l*W_WORD +: W_WORD] >> W_OUT;
                end
            end
            for (int unsigned l = 0; l < N_LANES; l++) begin
                out_p_d[l*W_OUT +: W_OUT] = shift_q[l*W_WORD +: W_OUT] ^ {W_OUT{invert[l]}};
                out_n_d[l*W_OUT +: W_OUT] = ~(shift_q[l*W_WORD +: W_OUT] ^ {W_OUT{invert[l]}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            phase_q     <= '0;
            shift_q     <= '0;
            out_p_q     <= '0;
            out_n_q     <= '0;
            udf_pend_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            shift_q     <= shift_d;
            out_p_q     <= out_p_d;
            out_n_q     <= out_n_d;
            udf_pend_q  <= udf_pend_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_multilane_ddr_serialiser.sv
// Directed bench for multilane_ddr_serialiser (3 lanes, 10-bit words, 2 bits per clock, depth 2).
module tb_multilane_ddr_serialiser;
    localparam int unsigned NL = 3;
    localparam int unsigned WW = 10;
    localparam int unsigned WO = 2;
    localparam int unsigned DP = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [NL*WW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [NL*WW-1:0] idle_word;
    logic [NL-1:0]    invert;
    logic [NL*WO-1:0] out_p;
    logic [NL*WO-1:0] out_n;
    logic             underflow;

    always #5 clk = ~clk;

    multilane_ddr_serialiser #(.N_LANES(NL), .W_WORD(WW), .W_OUT(WO), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .idle_word(idle_word),
        .invert   (invert),
        .out_p    (out_p),
        .out_n    (out_n),
        .underflow(underflow)
    );

    int total = 0;
    int bad   = 0;
    int ph     = 0;
    int mcount = 0;
    int idx    = 0;
    bit last_acc;

    logic [9:0] w3 [4]  = '{10'h0E4, 10'h31B, 10'h1B1, 10'h364};
    int         s3 [20] = '{0,1,2,3,0, 3,2,1,0,3, 1,0,3,2,1, 0,1,2,1,3};
    int         p364 [5] = '{0,1,2,1,3};
    int         n364 [5] = '{3,2,1,2,0};
    int         s31b [5] = '{3,2,1,0,3};
    int         s1b1 [5] = '{1,0,3,2,1};
    logic [5:0] e6p [5] = '{6'h00, 6'h05, 6'h0A, 6'h0D, 6'h03};
    logic [5:0] e6n [5] = '{6'h3F, 6'h3A, 6'h35, 6'h32, 6'h3C};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: checks in_ready against the occupancy model, then advances phase/occupancy models.
    task automatic step();
        logic exp_rdy;
        logic pop;
        exp_rdy  = (mcount != DP);
        chk("in_ready", in_ready, exp_rdy);
        last_acc = in_valid && exp_rdy;
        pop      = en && (ph == 0) && (mcount > 0);
        @(posedge clk);
        if (!rst_n) begin
            mcount = 0;
            ph     = 0;
        end else begin
            mcount = mcount + (last_acc ? 1 : 0) - (pop ? 1 : 0);
            ph     = en ? (ph + 1) % 5 : 0;
        end
        #1;
    endtask

    task automatic go_ph(input int p);
        for (int i = 0; i < 10 && ph != p; i++) step();
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; idle_word = '0; invert = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_p", out_p, 0);
        chk("rst_out_n", out_n, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // 1: idle words only
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("t1_out_p", out_p, 0);
            chk("t1_out_n", out_n, 6'h3F);
            chk("t1_underflow", underflow, (i % 5 == 2) ? 1 : 0);
        end

        // 2: single word accepted one cycle before a load edge
        go_ph(4);
        in_data = {20'h0, 10'h364}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t2_udf_at_load", underflow, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_beat_p", out_p[1:0], p364[k]);
            chk("t2_beat_n", out_n[1:0], n364[k]);
            chk("t2_underflow", underflow, 0);
        end

        // 3: continuous in_valid, gap-free stream of four words
        idx = 0; in_data = {20'h0, w3[0]}; in_valid = 1'b1;
        for (int j = 0; j < 25; j++) begin
            step();
            if (last_acc) begin
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else in_data = {20'h0, w3[idx]};
            end
            if (j >= 5) begin
                chk("t3_beat", out_p, s3[j-5]);
                chk("t3_underflow", underflow, 0);
            end
        end

        // 4: invert lane 0 mid-word
        go_ph(4);
        in_data = {20'h0, 10'h364}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step(); chk("t4_beat0", out_p[1:0], 0);
        step(); chk("t4_beat1", out_p[1:0], 1);
        invert = 3'b001;
        step();
        chk("t4_inv_beat2_p", out_p, 6'h01);
        chk("t4_inv_beat2_n", out_n, 6'h3E);
        step();
        chk("t4_inv_beat3_p", out_p[1:0], 2);
        chk("t4_inv_beat3_n", out_n[1:0], 1);
        step();
        chk("t4_inv_beat4_p", out_p[1:0], 0);
        chk("t4_inv_beat4_n", out_n[1:0], 3);
        invert = 3'b000;

        // 5: drop enable mid-word; partial word discarded, next word starts at beat 0
        in_data = {20'h0, 10'h0E4}; in_valid = 1'b1;
        step();
        in_data = {20'h0, 10'h31B};
        step();
        in_valid = 1'b0;
        step(); step(); step();
        step(); chk("t5_y1_beat0", out_p[1:0], 0);
        step(); chk("t5_y1_beat1", out_p[1:0], 1);
        en = 1'b0;
        in_data = {20'h0, 10'h1B1}; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1'b0;
            chk("t5_off_out_p", out_p, 0);
            chk("t5_off_out_n", out_n, 0);
            chk("t5_off_underflow", underflow, 0);
        end
        en = 1'b1;
        step();
        chk("t5_reen_out_p", out_p, 0);
        chk("t5_reen_out_n", out_n, 6'h3F);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_y2_beat", out_p[1:0], s31b[k]);
            chk("t5_y2_underflow", underflow, 0);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_y3_beat", out_p[1:0], s1b1[k]);
            chk("t5_y3_underflow", underflow, 0);
        end

        // 6: three lanes in lockstep, lane 2 pushed as zero, then async reset mid-word
        idle_word = {10'h3FF, 20'h0};
        go_ph(4);
        in_data = {10'h000, 10'h0E4, 10'h364}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_lanes_p", out_p, e6p[k]);
            chk("t6_lanes_n", out_n, e6n[k]);
        end
        step();
        chk("t6_idle_p", out_p, 6'h30);
        chk("t6_idle_n", out_n, 6'h0F);
        chk("t6_idle_underflow", underflow, 1);
        in_data = 30'h155; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_idle_beat1_p", out_p, 6'h30);
        chk("t6_idle_beat1_udf", underflow, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_p", out_p, 0);
        chk("t6_rst_out_n", out_n, 0);
        chk("t6_rst_underflow", underflow, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        mcount = 0; ph = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_load_p", out_p, 0);
        chk("t6_post_load_udf", underflow, 0);
        step();
        chk("t6_post_idle_p", out_p, 6'h30);
        chk("t6_post_udf", underflow, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
